detector_jogada: RTL and testbench

DETECTOR_JOGADA -- requirements
Module: detector_jogada

---
 rtl/detector_jogada.sv | 133 +++++++++++++
 tb/tb_detector_jogada.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/detector_jogada.sv
// Debounced key-press detector: filters a 4-bit key pattern, emits one move per press.
// Optional: define DETECTOR_JOGADA_ONEHOT_CHECK_EN to reject multi-key patterns via INVALIDA.
module detector_jogada #(
    parameter int DEBOUNCE_CICLOS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] chaves,
    output logic [3:0] jogada,
    output logic       jogada_feita,
    output logic       jogada_invalida,
    output logic [2:0] db_estado
);

    typedef enum logic [2:0] {
        ESPERA   = 3'd0,
        FILTRA   = 3'd1,
        EMITE    = 3'd2,
        INVALIDA = 3'd3,
        SOLTAR   = 3'd4
    } estado_t;

    localparam logic [9:0] CNT_MAX = 10'(DEBOUNCE_CICLOS);

    estado_t    estado, estado_prox;
    logic [9:0] cnt, cnt_prox;
    logic [3:0] amostra, amostra_prox;
    logic [3:0] jogada_prox;
    logic [3:0] chaves_s;
    logic [3:0] bit_menor;

    // Isolating the lowest set bit keeps a multi-key pattern from producing a non-one-hot move.
    assign bit_menor = amostra & (~amostra + 4'd1);

`ifdef DETECTOR_JOGADA_ONEHOT_CHECK_EN
    logic multi_bit;
    assign multi_bit = (amostra & (amostra - 4'd1)) != 4'd0;
`endif

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= SOLTAR;
            cnt      <= '0;
            amostra  <= '0;
            chaves_s <= '0;
            jogada   <= '0;
        end else begin
            estado   <= estado_prox;
            cnt      <= cnt_prox;
            amostra  <= amostra_prox;
            chaves_s <= chaves;
            jogada   <= jogada_prox;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        estado_prox  = estado;
        cnt_prox     = cnt;
        amostra_prox = amostra;
        jogada_prox  = jogada;

        case (estado)
            ESPERA: begin
                if (chaves_s != 4'd0) begin
                    amostra_prox = chaves_s;
                    cnt_prox     = 10'd1;
                    estado_prox  = FILTRA;
                end else begin
                    cnt_prox = '0;
                end
            end

            FILTRA: begin
                if (chaves_s == 4'd0) begin
                    estado_prox = ESPERA;
                    cnt_prox    = '0;
                end else if (chaves_s == amostra) begin
                    if (cnt < CNT_MAX) begin
                        cnt_prox = cnt + 10'd1;
                    end else begin
`ifdef DETECTOR_JOGADA_ONEHOT_CHECK_EN
                        if (multi_bit) begin
                            estado_prox = INVALIDA;
                        end else begin
                            estado_prox = EMITE;
                            jogada_prox = bit_menor;
                        end
`else
                        estado_prox = EMITE;
                        jogada_prox = bit_menor;
`endif
                    end
                end else begin
                    // A different pattern restarts the filter on the new sample.
                    amostra_prox = chaves_s;
                    cnt_prox     = 10'd1;
                end
            end

            EMITE, INVALIDA: begin
                estado_prox = SOLTAR;
                cnt_prox    = '0;
            end

            SOLTAR: begin
                if (cnt >= CNT_MAX) begin
                    estado_prox = ESPERA;
                    cnt_prox    = '0;
                end else if (chaves_s == 4'd0) begin
                    cnt_prox = cnt + 10'd1;
                end else begin
                    cnt_prox = '0;
                end
            end

            default: begin
                estado_prox = SOLTAR;
                cnt_prox    = '0;
            end
        endcase
    end

    assign jogada_feita = (estado == EMITE);
`ifdef DETECTOR_JOGADA_ONEHOT_CHECK_EN
    assign jogada_invalida = (estado == INVALIDA);
`else
    assign jogada_invalida = 1'b0;
`endif
    assign db_estado = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada (DEBOUNCE_CICLOS=3): reset, debounce, bounce,
// multi-key, reset mid-filter and an eight-round press sequence.
module tb_detector_jogada;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] chaves;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       jogada_invalida;
    logic [2:0] db_estado;

    int passes  = 0;
    int total   = 0;
    int n_feita = 0;
    int n_inval = 0;

    detector_jogada #(.DEBOUNCE_CICLOS(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .chaves         (chaves),
        .jogada         (jogada),
        .jogada_feita   (jogada_feita),
        .jogada_invalida(jogada_invalida),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: observe 1 time unit after the rising edge and tally output pulses.
    task automatic step();
        @(posedge clock);
        #1;
        if (jogada_feita === 1'b1)    n_feita++;
        if (jogada_invalida === 1'b1) n_inval++;
    endtask

    // Release keys and wait (bounded) for the FSM to return to ESPERA.
    task automatic release_keys(input string tag);
        chaves = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            step();
            if (db_estado == 3'd0) break;
        end
        check(tag, 32'(db_estado), 32'd0);
    endtask

    initial begin
        int base;
        logic [3:0] key;

        // Reset release: SOLTAR for exactly 3 observed cycles, then ESPERA.
        reset  = 1'b1;
        chaves = 4'b0000;
        repeat (10) step();
        check("rst_estado", 32'(db_estado), 32'd4);
        check("rst_jogada", 32'(jogada), 32'd0);
        check("rst_feita", 32'(jogada_feita), 32'd0);
        check("rst_invalida", 32'(jogada_invalida), 32'd0);
        reset = 1'b0;
        step(); check("rel_e1", 32'(db_estado), 32'd4);
        step(); check("rel_e2", 32'(db_estado), 32'd4);
        step(); check("rel_e3", 32'(db_estado), 32'd4);
        step(); check("rel_e4", 32'(db_estado), 32'd0);
        check("rel_pulses", 32'(n_feita + n_inval), 32'd0);

        // Single key 0001: 5 on, 5 off; pulse observed right after E4.
        chaves = 4'b0001;
        step(); check("s_e0_estado", 32'(db_estado), 32'd0);
        step(); check("s_e1_estado", 32'(db_estado), 32'd1);
        step(); check("s_e2_feita", 32'(jogada_feita), 32'd0);
        step(); check("s_e3_feita", 32'(jogada_feita), 32'd0);
        check("s_e3_jogada", 32'(jogada), 32'd0);
        step(); check("s_e4_feita", 32'(jogada_feita), 32'd1);
        check("s_e4_jogada", 32'(jogada), 32'b0001);
        chaves = 4'b0000;
        step(); check("s_e5_feita", 32'(jogada_feita), 32'd0);
        check("s_e5_estado", 32'(db_estado), 32'd4);
        step(); step(); step();
        check("s_e8_estado", 32'(db_estado), 32'd4);
        step(); check("s_e9_estado", 32'(db_estado), 32'd0);
        check("s_pulses", 32'(n_feita), 32'd1);
        check("s_hold", 32'(jogada), 32'b0001);

        // Bounce: 0010/0000 toggling for 6 cycles, then stable 0010.
        base = n_feita;
        for (int i = 0; i < 6; i++) begin
            chaves = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            step();
        end
        check("b_toggle_pulses", 32'(n_feita - base), 32'd0);
        chaves = 4'b0010;
        step(); step(); step(); step();
        check("b_e3_feita", 32'(jogada_feita), 32'd0);
        step();
        check("b_e4_feita", 32'(jogada_feita), 32'd1);
        check("b_e4_jogada", 32'(jogada), 32'b0010);
        release_keys("b_release");
        check("b_pulses", 32'(n_feita - base), 32'd1);

        // Multi-key 0110 held 6 cycles.
        base = n_feita;
        n_inval = 0;
        chaves = 4'b0110;
        repeat (6) step();
        release_keys("m_release");
        check("m_jogada", 32'(jogada), 32'b0010);
`ifdef DETECTOR_JOGADA_ONEHOT_CHECK_EN
        check("m_feita_cnt", 32'(n_feita - base), 32'd0);
        check("m_inval_cnt", 32'(n_inval), 32'd1);
`else
        check("m_feita_cnt", 32'(n_feita - base), 32'd1);
        check("m_inval_cnt", 32'(n_inval), 32'd0);
`endif

        // Reset mid-filter (cnt=2) with 1000 held, then release 3 cycles and re-press.
        base = n_feita;
        chaves = 4'b1000;
        step(); step();
        check("r_filtra_e1", 32'(db_estado), 32'd1);
        step();
        check("r_filtra_e2", 32'(db_estado), 32'd1);
        reset = 1'b1;
        step();
        check("r_rst_estado", 32'(db_estado), 32'd4);
        check("r_rst_jogada", 32'(jogada), 32'd0);
        reset = 1'b0;
        repeat (6) step();
        check("r_held_estado", 32'(db_estado), 32'd4);
        check("r_held_pulses", 32'(n_feita - base), 32'd0);
        chaves = 4'b0000;
        step(); step(); step();
        check("r_g2_estado", 32'(db_estado), 32'd4);
        chaves = 4'b1000;
        step(); check("r_g3_estado", 32'(db_estado), 32'd4);
        step(); check("r_g4_estado", 32'(db_estado), 32'd0);
        step(); step(); step();
        check("r_g7_feita", 32'(jogada_feita), 32'd0);
        step();
        check("r_g8_feita", 32'(jogada_feita), 32'd1);
        check("r_g8_jogada", 32'(jogada), 32'b1000);
        release_keys("r_release");
        check("r_pulses", 32'(n_feita - base), 32'd1);

        // Eight rounds of 1..8 presses, 5 cycles on / 5 off: 36 moves.
        base = n_feita;
        for (int r = 1; r <= 8; r++) begin
            for (int p = 0; p < r; p++) begin
                key = 4'b0001 << ((r + p) % 4);
                chaves = key;
                for (int c = 0; c < 5; c++) begin
                    step();
                    if (jogada_feita === 1'b1) check("seq_jogada", 32'(jogada), 32'(key));
                end
                chaves = 4'b0000;
                repeat (5) step();
            end
        end
        check("seq_estado", 32'(db_estado), 32'd0);
        check("seq_pulses", 32'(n_feita - base), 32'd36);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
